weight_buffer_loader: RTL and testbench
=======================================

# weight_buffer_loader

Write-side sequencer for the weight buffer: accepts a load command (start address, row count) and a 512-bit weight stream, and drives the buffer's `data_wr` / `wr_addr` / `wr_en` write port. It fills every bank of one address row before advancing to the next address. It sits between the DDR/DMA read stream and the weight buffer, and signals completion so the controller can issue `rd_conf` safely.

## Interface
- `X_PE`, 16, PE count per mesh; must match the weight buffer.
- `X_MESH`, 16, mesh count; must match the weight buffer.
- `ADDR_LEN`, 16, bank address width.
- `DATA_LEN`, 64, bank data width.
- `BUFFER_NUM`, `8*X_PE*X_MESH/DATA_LEN` (32), bank count; must be a multiple of 8.
- `GROUPS`, `BUFFER_NUM/8` (4), beats per address row.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  load command valid.
- `cmd_ready`  out  1  loader accepts a command; high only in IDLE.
- `cmd_addr`  in  `ADDR_LEN`  first row address.
- `cmd_rows`  in  `ADDR_LEN+1`  number of rows to load; 0 is legal.
- `s_data`  in  `DATA_LEN*8`  weight beat.
- `s_valid`  in  1  beat valid.
- `s_ready`  out  1  beat accepted when `s_valid && s_ready`.
- `data_wr`  out  `DATA_LEN*8`  write data to the buffer (registered).
- `wr_addr`  out  `ADDR_LEN`  write address (registered).
- `wr_en`  out  `BUFFER_NUM`  per-bank write enable (registered).
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, LOAD and DONE.
  - IDLE: `cmd_ready=1`. When `cmd_valid` is high, latch `addr=cmd_addr`, `rows_left=cmd_rows` and `grp=0`. Go to DONE if `cmd_rows==0`, otherwise to LOAD.
  - LOAD: `s_ready=1`. Each accepted beat is registered to `data_wr`, with `wr_addr=addr` and `wr_en=8'hFF<<(8*grp)`.
    - Then `grp++`. When `grp==GROUPS-1`, set `grp=0`, `addr++`, `rows_left--`.
    - On the last beat (`grp==GROUPS-1 && rows_left==1`), go to DONE.
  - DONE: `done=1` for one cycle, then go to IDLE.
- Beat-to-bank mapping: beat g of a row writes banks `8g..8g+7`. Bank `8g+b` receives `s_data[b*DATA_LEN +: DATA_LEN]`.
- Address arithmetic is modulo `2^ADDR_LEN`; `0xFFFF+1` wraps to 0 silently.
- `wr_en` is all-zero in every cycle that has no accepted beat in the previous cycle. `data_wr` holds its last value (don't-care when `wr_en==0`).
- `cmd_valid` outside IDLE is ignored, and the command is not consumed.
- A gap in `s_valid` stalls the sequence with no penalty and no bubble write.

## Timing
- Reset values: state=IDLE, `cmd_ready=1`, `s_ready=0`, `wr_en=0`, `wr_addr=0`, `data_wr=0`, `busy=0`, `done=0`.
- Command accepted at edge N gives `s_ready=1` from cycle N+1.
- Beat accepted at edge M gives the write on the port during cycle M+1, exactly one cycle.
- Last beat accepted at edge M:
  - the final write and `done=1` are both in cycle M+1;
  - `s_ready=0` in cycle M+1;
  - `cmd_ready=1` in cycle M+2.
- The buffer commits the final write at the same edge that samples `done`. `rd_conf` may therefore be issued the cycle after `done`.
- With `rows=0`: command at edge N gives `done` in cycle N+1, no writes.
- Throughput: one beat per cycle sustained; a row takes `GROUPS` cycles.
- Reset mid-LOAD aborts immediately: `wr_en=0` next cycle, no `done`, counters cleared. A partially written row is left as is.

## Structure
- Shared package `wbuf_pkg` holds:
  - the state enum (`WL_IDLE`, `WL_LOAD`, `WL_DONE`);
  - the `BUFFER_NUM` / `GROUPS` derivation function;
  - the `BEAT_W = DATA_LEN*8` constant.
- Single module with no sub-module. The counters and enable decode are small enough to stay inline.

## Test plan
- Reset, then `cmd_addr=0x0010`, `rows=1`, with 4 back-to-back beats D0..D3:
  - writes at addr 0x10 with `wr_en` = 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000 in consecutive cycles;
  - `done` is in the cycle with the 4th write.
- `rows=9`, `addr=0x0100`, continuous stream: 36 writes covering addr 0x100..0x108; `done` one cycle after the 36th beat is accepted.
- Same as above with `s_valid` deasserted on every third cycle: identical write sequence and no write with `wr_en!=0` during gaps.
- `addr=0xFFFF`, `rows=2`: the first 4 writes go to 0xFFFF and the next 4 to 0x0000.
- `rows=0`: `done` in the next cycle, `wr_en` stays 0, and `cmd_ready` is back the following cycle. A second `cmd_valid` during LOAD is ignored.
- Assert `rst_n=0` after 2 beats of a `rows=1` load: `wr_en=0` the next cycle, no `done`, and `cmd_ready=1` after reset release.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared definitions for the weight buffer write path.
// Latency: none (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: loader state encoding, bank-count/beat-count derivation, beat width.
package wbuf_pkg;

  typedef enum logic [1:0] {
    WL_IDLE = 2'd0,
    WL_LOAD = 2'd1,
    WL_DONE = 2'd2
  } wl_state_t;

  localparam int DEF_DATA_LEN = 64;

  // One beat always carries eight bank words.
  function automatic int beat_w(input int data_len);
    return data_len * 8;
  endfunction

  localparam int BEAT_W = beat_w(DEF_DATA_LEN);

  // Total bank count for a mesh array; must come out as a multiple of 8.
  function automatic int calc_buffer_num(input int x_pe, input int x_mesh, input int data_len);
    return (8 * x_pe * x_mesh) / data_len;
  endfunction

  // Beats needed to cover every bank of one address row.
  function automatic int calc_groups(input int buffer_num);
    return buffer_num / 8;
  endfunction

endpackage

// File: rtl/weight_buffer_loader.sv
// Write-side sequencer for the weight buffer: (start addr, rows) command + beat stream -> bank writes.
// Latency: an accepted beat is on data_wr/wr_addr/wr_en exactly one cycle later; done shares the last write's cycle.
// Backpressure: cmd_ready only in IDLE, s_ready only in LOAD; s_valid gaps stall without bubble writes.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_rows   load command handshake (rows==0 completes immediately)
//   s_data/s_valid/s_ready        512-bit weight beat stream
//   data_wr/wr_addr/wr_en         registered buffer write port, one-hot group of 8 bank enables
//   busy, done                    busy in LOAD/DONE; done is a one-cycle completion pulse
module weight_buffer_loader
  import wbuf_pkg::*;
#(
  parameter int X_PE       = 16,
  parameter int X_MESH     = 16,
  parameter int ADDR_LEN   = 16,
  parameter int DATA_LEN   = 64,
  parameter int BUFFER_NUM = calc_buffer_num(X_PE, X_MESH, DATA_LEN),
  parameter int GROUPS     = calc_groups(BUFFER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_LEN-1:0]   cmd_addr,
  input  logic [ADDR_LEN:0]     cmd_rows,
  input  logic [DATA_LEN*8-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_LEN*8-1:0] data_wr,
  output logic [ADDR_LEN-1:0]   wr_addr,
  output logic [BUFFER_NUM-1:0] wr_en,
  output logic                  busy,
  output logic                  done
);

  localparam int BEAT_BITS = beat_w(DATA_LEN);
  // Keep the group counter at least one bit wide even for a single-group configuration.
  localparam int GRP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  wl_state_t             state_q, state_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [ADDR_LEN:0]     rows_left_q, rows_left_d;
  logic [GRP_W-1:0]      grp_q, grp_d;
  logic [BEAT_BITS-1:0]  data_wr_q, data_wr_d;
  logic [ADDR_LEN-1:0]   wr_addr_q, wr_addr_d;
  logic [BUFFER_NUM-1:0] wr_en_q, wr_en_d;
  logic                  last_grp;

  assign last_grp = (grp_q == GRP_W'(GROUPS - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rows_left_d = rows_left_q;
    grp_d       = grp_q;
    data_wr_d   = data_wr_q;   // holds last value when no write
    wr_addr_d   = wr_addr_q;
    wr_en_d     = '0;          // enables are strictly per accepted beat

    case (state_q)
      WL_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          rows_left_d = cmd_rows;
          grp_d       = '0;
          state_d     = (cmd_rows == '0) ? WL_DONE : WL_LOAD;
        end
      end

      WL_LOAD: begin
        if (s_valid) begin
          data_wr_d = s_data;
          wr_addr_d = addr_q;
          // Beat g of a row lands in banks 8g..8g+7.
          for (int g = 0; g < GROUPS; g++) begin
            if (grp_q == GRP_W'(g)) begin
              wr_en_d[8*g +: 8] = 8'hFF;
            end
          end
          if (last_grp) begin
            grp_d       = '0;
            addr_d      = addr_q + ADDR_LEN'(1);   // wraps modulo 2^ADDR_LEN
            rows_left_d = rows_left_q - (ADDR_LEN+1)'(1);
            if (rows_left_q == (ADDR_LEN+1)'(1)) begin
              state_d = WL_DONE;
            end
          end else begin
            grp_d = grp_q + GRP_W'(1);
          end
        end
      end

      WL_DONE: begin
        state_d = WL_IDLE;
      end

      default: begin
        state_d = WL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WL_IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      grp_q       <= '0;
      data_wr_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rows_left_q <= rows_left_d;
      grp_q       <= grp_d;
      data_wr_q   <= data_wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign cmd_ready = (state_q == WL_IDLE);
  assign s_ready   = (state_q == WL_LOAD);
  assign busy      = (state_q == WL_LOAD) || (state_q == WL_DONE);
  // The final write is on the port in this same cycle, so the buffer commits it
  // at the edge that samples done.
  assign done      = (state_q == WL_DONE);

  assign data_wr = data_wr_q;
  assign wr_addr = wr_addr_q;
  assign wr_en   = wr_en_q;

endmodule

// File: tb/tb_weight_buffer_loader.sv
module tb_weight_buffer_loader;
  import wbuf_pkg::*;

  localparam int AL = 16;
  localparam int BN = 32;
  localparam int GR = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AL-1:0]   cmd_addr = '0;
  logic [AL:0]     cmd_rows = '0;
  logic [BEAT_W-1:0] s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [BEAT_W-1:0] data_wr;
  logic [AL-1:0]   wr_addr;
  logic [BN-1:0]   wr_en;
  logic            busy;
  logic            done;

  weight_buffer_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rows  (cmd_rows),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .data_wr   (data_wr),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int writes_seen = 0;
  int done_cnt = 0;

  logic [AL-1:0]     exp_addr_q[$];
  logic [BN-1:0]     exp_en_q[$];
  logic [BEAT_W-1:0] exp_dat_q[$];

  task automatic chk(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat(input int k);
    logic [BEAT_W-1:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = 32'(k * 16 + i) ^ 32'hC3A5_0000;
    return v;
  endfunction

  // Advance one clock, then check any write on the port against the expected queue.
  task automatic tick();
    logic [AL-1:0]     ea;
    logic [BN-1:0]     ee;
    logic [BEAT_W-1:0] ed;
    @(posedge clk);
    #1;
    if (wr_en != '0) begin
      writes_seen++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write", BEAT_W'(wr_en), '0);
      end else begin
        ea = exp_addr_q.pop_front();
        ee = exp_en_q.pop_front();
        ed = exp_dat_q.pop_front();
        chk("wr_addr", BEAT_W'(wr_addr), BEAT_W'(ea));
        chk("wr_en", BEAT_W'(wr_en), BEAT_W'(ee));
        chk("data_wr", data_wr, ed);
      end
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run_load(input logic [AL-1:0] a, input int rows, input bit gaps,
                          input bit poke, input string tag);
    int total;
    int k;
    int c;
    int budget;
    int w0;
    bit acc;
    total = rows * GR;
    k = 0;
    c = 0;
    budget = 400;
    w0 = writes_seen;
    done_cnt = 0;
    for (int r = 0; r < rows; r++) begin
      for (int g = 0; g < GR; g++) begin
        exp_addr_q.push_back(a + AL'(r));
        exp_en_q.push_back(BN'(32'h0000_00FF << (8 * g)));
        exp_dat_q.push_back(beat(r * GR + g));
      end
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rows  = (AL+1)'(rows);
    tick();
    cmd_valid = poke;
    if (poke) begin
      cmd_addr = 16'hBEEF;
      cmd_rows = 17'd5;
    end
    chk({tag, "_s_ready_after_cmd"}, BEAT_W'(s_ready), 1);
    chk({tag, "_busy_after_cmd"}, BEAT_W'(busy), 1);
    while (k < total && budget > 0) begin
      if (poke) cmd_valid = (k < 2);
      s_valid = gaps ? (c % 3 != 2) : 1'b1;
      s_data  = beat(k);
      acc = s_valid && s_ready;
      tick();
      if (acc) k++;
      else chk({tag, "_no_bubble_write"}, BEAT_W'(wr_en), '0);
      c++;
      budget--;
      if (poke && k < total) chk({tag, "_cmd_ready_in_load"}, BEAT_W'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    s_valid   = 1'b0;
    chk({tag, "_beats_accepted"}, BEAT_W'(k), BEAT_W'(total));
    chk({tag, "_done_with_last_write"}, BEAT_W'(done), 1);
    chk({tag, "_last_write_present"}, BEAT_W'(wr_en != '0), 1);
    chk({tag, "_s_ready_low_at_done"}, BEAT_W'(s_ready), 0);
    chk({tag, "_expected_left"}, BEAT_W'(exp_addr_q.size()), 0);
    tick();
    chk({tag, "_cmd_ready_after_done"}, BEAT_W'(cmd_ready), 1);
    chk({tag, "_done_one_cycle"}, BEAT_W'(done), 0);
    chk({tag, "_wr_en_idle"}, BEAT_W'(wr_en), 0);
    chk({tag, "_done_pulses"}, BEAT_W'(done_cnt), 1);
    chk({tag, "_write_count"}, BEAT_W'(writes_seen - w0), BEAT_W'(total));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", BEAT_W'(cmd_ready), 1);
    chk("rst_s_ready", BEAT_W'(s_ready), 0);
    chk("rst_wr_en", BEAT_W'(wr_en), 0);
    chk("rst_wr_addr", BEAT_W'(wr_addr), 0);
    chk("rst_data_wr", data_wr, '0);
    chk("rst_busy", BEAT_W'(busy), 0);
    chk("rst_done", BEAT_W'(done), 0);
    rst_n = 1'b1;
    tick();

    // Single row, back-to-back beats
    run_load(16'h0010, 1, 1'b0, 1'b0, "row1");
    // Nine rows, continuous, then with every third cycle idle
    run_load(16'h0100, 9, 1'b0, 1'b0, "row9");
    run_load(16'h0100, 9, 1'b1, 1'b0, "row9gap");
    // Address wrap
    run_load(16'hFFFF, 2, 1'b0, 1'b0, "wrap");

    // Zero-row command
    done_cnt = 0;
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0040;
    cmd_rows  = '0;
    tick();
    cmd_valid = 1'b0;
    chk("rows0_done", BEAT_W'(done), 1);
    chk("rows0_wr_en", BEAT_W'(wr_en), 0);
    chk("rows0_cmd_ready_low", BEAT_W'(cmd_ready), 0);
    chk("rows0_busy", BEAT_W'(busy), 1);
    tick();
    chk("rows0_cmd_ready_back", BEAT_W'(cmd_ready), 1);
    chk("rows0_done_low", BEAT_W'(done), 0);
    chk("rows0_wr_en_idle", BEAT_W'(wr_en), 0);

    // Second command while loading is ignored
    run_load(16'h0020, 1, 1'b0, 1'b1, "poke");

    // Reset after two beats of a one-row load
    done_cnt = 0;
    for (int g = 0; g < 2; g++) begin
      exp_addr_q.push_back(16'h0050);
      exp_en_q.push_back(BN'(32'h0000_00FF << (8 * g)));
      exp_dat_q.push_back(beat(g));
    end
    cmd_valid = 1'b1;
    cmd_addr  = 16'h0050;
    cmd_rows  = 17'd1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_data  = beat(k);
      tick();
    end
    chk("rst_mid_second_write", BEAT_W'(wr_en), BEAT_W'(32'h0000_FF00));
    rst_n = 1'b0;
    s_data = beat(2);
    tick();
    chk("rst_mid_wr_en", BEAT_W'(wr_en), 0);
    chk("rst_mid_done", BEAT_W'(done), 0);
    chk("rst_mid_s_ready", BEAT_W'(s_ready), 0);
    chk("rst_mid_busy", BEAT_W'(busy), 0);
    rst_n = 1'b1;
    s_valid = 1'b0;
    tick();
    chk("rst_mid_cmd_ready", BEAT_W'(cmd_ready), 1);
    chk("rst_mid_no_done", BEAT_W'(done_cnt), 0);
    chk("rst_mid_expected_left", BEAT_W'(exp_addr_q.size()), 0);
    // Counters must restart from group 0 on the next load
    run_load(16'h0030, 1, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
